ball_motion: RTL
================

BALL_MOTION -- requirements
Module: ball_motion

Parameters
REQ-001 The block SHALL have parameter X_CENTER, default 320, giving the reset and recentre X position.
REQ-002 The block SHALL have parameter Y_CENTER, default 240, giving the reset and recentre Y position.
REQ-003 The block SHALL have parameters X_MIN/X_MAX, defaults 0/639, giving the horizontal travel bounds.
REQ-004 The block SHALL have parameters Y_MIN/Y_MAX, defaults 0/479, giving the vertical travel bounds.
REQ-005 The block SHALL have parameter STEP, default 1, giving the pixels moved per frame on each moving axis.
REQ-006 The block SHALL have parameter SIZE, default 4, giving the ball radius driven on BallS.

Interface
REQ-007 The block SHALL have port Clk, input, 1 bit: the single system clock; all state is rising-edge.
REQ-008 The block SHALL have port Reset, input, 1 bit: synchronous, active-high.
REQ-009 The block SHALL have port frame_clk, input, 1 bit: the vertical-sync-rate frame strobe, asynchronous to Clk.
REQ-010 The block SHALL have port keycode, input, 8 bits: the current keyboard scan code, 0x00 when no key is pressed.
REQ-011 The block SHALL have port BallX, output, 10 bits: the ball centre X, unsigned, registered.
REQ-012 The block SHALL have port BallY, output, 10 bits: the ball centre Y, unsigned, registered.
REQ-013 The block SHALL have port BallS, output, 10 bits: the ball radius, constant SIZE.
REQ-014 The block SHALL have port frame_tick, output, 1 bit: a one-Clk pulse in the cycle that positions update.

Function
REQ-015 frame_clk SHALL pass through a two-flop synchroniser; a rising edge is detected from a third flop, giving one event per frame_clk rising edge.
REQ-016 A detected edge SHALL be acted on in the next Clk cycle: BallX/BallY update and frame_tick=1 in that same cycle; total latency is 4 Clk cycles or fewer from the frame_clk edge.
REQ-017 Between events, BallX, BallY, MotionX and MotionY SHALL hold their values.
REQ-018 MotionX and MotionY SHALL be 10-bit two's-complement step registers, each holding only the value -STEP, 0 or +STEP.
REQ-019 Keycode decode per event SHALL be: 0x1A (W) -> X=0, Y=-STEP; 0x16 (S) -> X=0, Y=+STEP; 0x04 (A) -> X=-STEP, Y=0; 0x07 (D) -> X=+STEP, Y=0; any other code -> motion unchanged.
REQ-020 Keycode 0x2C (space) SHALL toggle the paused flag once per press, on an event whose keycode is 0x2C when the previous event's keycode was not 0x2C; holding the key SHALL NOT re-toggle.
REQ-021 Keycode 0x15 (R) SHALL, on an event, set BallX=X_CENTER, BallY=Y_CENTER and MotionX=MotionY=0, and leave paused unchanged.
REQ-022 The per-axis boundary override SHALL be applied after keycode decode:
- BallY+SIZE >= Y_MAX -> MotionY=-STEP;
- else BallY <= Y_MIN+SIZE -> MotionY=+STEP;
- X axis identical using X_MIN/X_MAX;
- the other axis is unaffected.
REQ-023 Position update SHALL be BallX <= BallX+MotionX_new and BallY <= BallY+MotionY_new, using the motion values computed in that same event, with 10-bit modulo arithmetic.
REQ-024 While paused=1, events SHALL still update motion registers, the press history and frame_tick, but SHALL NOT change BallX/BallY, except that R still recentres.
REQ-025 Comparisons SHALL be done in 11-bit unsigned arithmetic so that BallY+SIZE cannot wrap.

Reset
REQ-026 Reset SHALL take priority over events in the same cycle.
REQ-027 On Reset: BallX=X_CENTER, BallY=Y_CENTER, MotionX=MotionY=0, paused=0, press history=0, synchroniser and edge flops=0, frame_tick=0.
REQ-028 BallS SHALL equal SIZE at all times, including during reset.
REQ-029 Reset asserted mid-frame SHALL discard any pending edge; the first event after Reset deasserts SHALL come from a new frame_clk rising edge.

Verification
REQ-030 Scenario: reset, then 3 frame_clk edges with keycode=0x07 -> BallX=323, BallY=240, exactly 3 frame_tick pulses.
REQ-031 Scenario: reset, keycode=0x16 held for 240 frames -> BallY climbs to 475, then decreases to 474 on the following frame (bounce); BallX stays 320.
REQ-032 Scenario: moving right, keycode=0x2C held for 5 frames, then 0x00 for 3 frames -> position frozen for all 8 frames, paused=1; a second press resumes motion.
REQ-033 Scenario: ball at (400,100), keycode=0x15 -> next event gives BallX=320, BallY=240, motion zero.
REQ-034 Scenario: Reset pulsed in the cycle the edge is detected -> no frame_tick, outputs at reset values.
REQ-035 Scenario: frame_clk held high for 1000 Clk cycles -> exactly one frame_tick pulse.

Source files
------------

// File: rtl/ball_motion.sv
// Moves a ball centre one step per frame strobe under keyboard control.
// Bounces off the configured bounds, and supports a pause toggle and a recentre key.
module ball_motion #(
   parameter int X_CENTER = 320,
   parameter int Y_CENTER = 240,
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 639,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = 479,
   parameter int STEP     = 1,
   parameter int SIZE     = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   output logic [9:0] BallX,
   output logic [9:0] BallY,
   output logic [9:0] BallS,
   output logic       frame_tick
);

   localparam logic [7:0]  KEY_W     = 8'h1A;
   localparam logic [7:0]  KEY_S     = 8'h16;
   localparam logic [7:0]  KEY_A     = 8'h04;
   localparam logic [7:0]  KEY_D     = 8'h07;
   localparam logic [7:0]  KEY_SPACE = 8'h2C;
   localparam logic [7:0]  KEY_R     = 8'h15;

   localparam logic [9:0]  STEP_POS  = 10'(STEP);
   localparam logic [9:0]  STEP_NEG  = ~STEP_POS + 10'd1;
   localparam logic [9:0]  X_CTR     = 10'(X_CENTER);
   localparam logic [9:0]  Y_CTR     = 10'(Y_CENTER);
   localparam logic [10:0] SIZE_W    = 11'(SIZE);
   localparam logic [10:0] X_HI      = 11'(X_MAX);
   localparam logic [10:0] Y_HI      = 11'(Y_MAX);
   localparam logic [10:0] X_LO      = 11'(X_MIN + SIZE);
   localparam logic [10:0] Y_LO      = 11'(Y_MIN + SIZE);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       sync3_q, sync3_d;
   logic [1:0] fill_q, fill_d;
   logic       armed_q, armed_d;
   logic [9:0] ball_x_q, ball_x_d;
   logic [9:0] ball_y_q, ball_y_d;
   logic [9:0] motion_x_q, motion_x_d;
   logic [9:0] motion_y_q, motion_y_d;
   logic       paused_q, paused_d;
   logic       prev_space_q, prev_space_d;
   logic       frame_tick_q, frame_tick_d;

   logic       frame_event;
   logic [9:0] mx, my;

   // The synchroniser reads 0 straight after reset, which is not a real low level.
   // Edges are only accepted once a genuine low has passed through, so a strobe
   // that was already high across reset never counts as a new frame.
   always_comb begin
      sync1_d      = frame_clk;
      sync2_d      = sync1_q;
      sync3_d      = sync2_q;
      fill_d       = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
      armed_d      = armed_q | ((fill_q == 2'd2) & ~sync2_q);
      ball_x_d     = ball_x_q;
      ball_y_d     = ball_y_q;
      motion_x_d   = motion_x_q;
      motion_y_d   = motion_y_q;
      paused_d     = paused_q;
      prev_space_d = prev_space_q;
      frame_tick_d = 1'b0;
      frame_event  = sync2_q & ~sync3_q & armed_q;

      mx = motion_x_q;
      my = motion_y_q;
      case (keycode)
         KEY_W:   begin mx = 10'd0;    my = STEP_NEG; end
         KEY_S:   begin mx = 10'd0;    my = STEP_POS; end
         KEY_A:   begin mx = STEP_NEG; my = 10'd0;    end
         KEY_D:   begin mx = STEP_POS; my = 10'd0;    end
         default: ;
      endcase
      if ({1'b0, ball_x_q} + SIZE_W >= X_HI) mx = STEP_NEG;
      else if ({1'b0, ball_x_q} <= X_LO)     mx = STEP_POS;
      if ({1'b0, ball_y_q} + SIZE_W >= Y_HI) my = STEP_NEG;
      else if ({1'b0, ball_y_q} <= Y_LO)     my = STEP_POS;

      if (frame_event) begin
         frame_tick_d = 1'b1;
         prev_space_d = (keycode == KEY_SPACE);
         if (keycode == KEY_R) begin
            ball_x_d   = X_CTR;
            ball_y_d   = Y_CTR;
            motion_x_d = 10'd0;
            motion_y_d = 10'd0;
         end else begin
            if ((keycode == KEY_SPACE) && !prev_space_q) paused_d = ~paused_q;
            motion_x_d = mx;
            motion_y_d = my;
            if (!paused_d) begin
               ball_x_d = ball_x_q + mx;
               ball_y_d = ball_y_q + my;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         sync3_q      <= 1'b0;
         fill_q       <= 2'd0;
         armed_q      <= 1'b0;
         ball_x_q     <= X_CTR;
         ball_y_q     <= Y_CTR;
         motion_x_q   <= 10'd0;
         motion_y_q   <= 10'd0;
         paused_q     <= 1'b0;
         prev_space_q <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         sync3_q      <= sync3_d;
         fill_q       <= fill_d;
         armed_q      <= armed_d;
         ball_x_q     <= ball_x_d;
         ball_y_q     <= ball_y_d;
         motion_x_q   <= motion_x_d;
         motion_y_q   <= motion_y_d;
         paused_q     <= paused_d;
         prev_space_q <= prev_space_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign BallX      = ball_x_q;
   assign BallY      = ball_y_q;
   assign BallS      = 10'(SIZE);
   assign frame_tick = frame_tick_q;

endmodule
